// File: rtl/display_pkg.sv
// Shared state type and segment constants for the seven-segment scan controller.
package display_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] ANODE_OFF = 4'hF;

   // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   localparam logic [15:0][6:0] SEG_TABLE = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9,
                                             SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2,
                                             SEG_1, SEG_0};

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with blanking gaps, leading-zero
// suppression and frame-synchronous value updates.
module display_scan_controller
   import display_pkg::*;
#(
   parameter int unsigned CLOCK_DIVIDE = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] value_data,
   input  logic [3:0]  point_data,
   input  logic        value_valid,
   output logic        value_ready,
   input  logic        suppress_zeros,
   output logic [3:0]  anode,
   output logic [6:0]  cathode,
   output logic        dp,
   output logic        frame_done
);

   localparam int unsigned CNT_W = $clog2(CLOCK_DIVIDE);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLOCK_DIVIDE - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   scan_state_e      state_q;
   logic [1:0]       digit_q;
   logic [CNT_W-1:0] slot_cnt_q;

   logic [15:0] display_value_q;
   logic [3:0]  display_point_q;
   logic [15:0] pending_value_q;
   logic [3:0]  pending_point_q;
   logic        pending_full_q;
   logic        suppress_q;

   logic [3:0] anode_q;
   logic [6:0] cathode_q;
   logic       dp_q;

   logic       boundary;
   logic       frame_start;
   logic       accept;
   logic       drive_now;
   logic [3:0] nibble;
   logic [6:0] digit_segments;
   logic [3:0] zero_blank;

   assign boundary    = enable && (state_q == DRIVE) && (digit_q == 2'd3) &&
                        (slot_cnt_q == SLOT_LAST);
   assign frame_start = enable && ((state_q == IDLE) || boundary);
   assign accept      = value_valid && !pending_full_q;
   assign drive_now   = enable && (state_q == DRIVE);

   assign value_ready = !pending_full_q;
   assign frame_done  = boundary;
   assign anode       = anode_q;
   assign cathode     = cathode_q;
   assign dp          = dp_q;

   assign nibble = display_value_q[{digit_q, 2'b00} +: 4];

   hex_to_seg7 u_hex_to_seg7 (
      .nibble   (nibble),
      .segments (digit_segments)
   );

   // A digit goes dark only if it and every more-significant nibble are zero
   always_comb begin
      zero_blank    = 4'b0000;
      zero_blank[3] = suppress_q && (display_value_q[15:12] == 4'h0);
      zero_blank[2] = zero_blank[3] && (display_value_q[11:8] == 4'h0);
      zero_blank[1] = zero_blank[2] && (display_value_q[7:4] == 4'h0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         display_value_q <= 16'h0000;
         display_point_q <= 4'h0;
         pending_value_q <= 16'h0000;
         pending_point_q <= 4'h0;
         pending_full_q  <= 1'b0;
         suppress_q      <= 1'b0;
      end else begin
         if (boundary && pending_full_q) begin
            display_value_q <= pending_value_q;
            display_point_q <= pending_point_q;
            pending_full_q  <= 1'b0;
         end else if (accept) begin
            pending_value_q <= value_data;
            pending_point_q <= point_data;
            pending_full_q  <= 1'b1;
         end
         if (frame_start) begin
            suppress_q <= suppress_zeros;
         end
      end
   end

   // Outputs lag the state by one cycle; gating with enable lets the display go
   // dark on the cycle right after enable falls.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         digit_q    <= 2'd0;
         slot_cnt_q <= '0;
         anode_q    <= ANODE_OFF;
         cathode_q  <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         if (!enable) begin
            state_q    <= IDLE;
            digit_q    <= 2'd0;
            slot_cnt_q <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q    <= BLANK;
                  digit_q    <= 2'd0;
                  slot_cnt_q <= '0;
               end
               BLANK: begin
                  slot_cnt_q <= slot_cnt_q + CNT_W'(1);
                  if (slot_cnt_q == BLANK_LAST) begin
                     state_q <= DRIVE;
                  end
               end
               DRIVE: begin
                  if (slot_cnt_q == SLOT_LAST) begin
                     state_q    <= BLANK;
                     digit_q    <= digit_q + 2'd1;
                     slot_cnt_q <= '0;
                  end else begin
                     slot_cnt_q <= slot_cnt_q + CNT_W'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end

         if (drive_now) begin
            anode_q   <= ~(4'b0001 << digit_q);
            cathode_q <= zero_blank[digit_q] ? SEG_BLANK : digit_segments;
            dp_q      <= ~display_point_q[digit_q];
         end else begin
            anode_q   <= ANODE_OFF;
            cathode_q <= SEG_BLANK;
            dp_q      <= 1'b1;
         end
      end
   end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

- Drives the 4-digit multiplexed seven-segment display from the system clock.
- Divides the clock into per-digit time slots and sequences the active-low anodes, inserting a blanking gap at the start of each slot to suppress ghosting.
- Decodes the selected hex nibble onto the active-low cathodes.
- New display values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never mixes old and new digits.
- Sits between the status/hash-rate logic and the board display pins.

## Interface
Parameters:
- CLOCK_DIVIDE, 100000: clock cycles per digit slot; must satisfy CLOCK_DIVIDE ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must satisfy 1 ≤ BLANK_CYCLES < CLOCK_DIVIDE.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  display on when high.
- value_data  in  16  four hex nibbles; [3:0] is digit 0 (rightmost).
- point_data  in  4  decimal points; bit n belongs to digit n, 1 = lit.
- value_valid  in  1  producer offers value_data/point_data.
- value_ready  out  1  pending buffer empty.
- suppress_zeros  in  1  leading-zero blanking; sampled at each frame start.
- anode  out  4  active-low digit enables; bit n = digit n.
- cathode  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse at end of each frame.

## Operation
Registers:
- Display register: 16-bit value plus 4 point bits.
- Pending buffer: 20 bits plus a full flag.

Handshake:
- Transfer occurs when value_valid && value_ready.
- value_ready = !pending_full.
- Data is captured into the pending buffer and pending_full is set.

Frame boundary (last cycle of digit 3's slot):
- If pending_full, copy pending into the display register and clear pending_full.
- value_ready rises on the following cycle.
- An offer made on the boundary cycle itself is refused, because ready is still low.

FSM states:
- IDLE: all anodes off.
- BLANK: all anodes off; slot counter is running.
- DRIVE: anode[digit] low.

FSM transitions:
- IDLE → BLANK(digit 0) when enable is high.
- BLANK → DRIVE after BLANK_CYCLES cycles.
- DRIVE → BLANK(digit+1) after the slot completes. The digit index is 2 bits and wraps 3→0.
- Any state → IDLE when enable is low. The digit index and slot counter are cleared; the pending buffer and display register are retained.

Leading-zero blanking (when suppress_zeros is sampled high):
- Digit n (n = 3, 2, 1) shows no segments when its nibble and all more-significant nibbles are 0.
- Digit 0 is never blanked.
- dp is unaffected by zero blanking.

Segment decode (cathode hex):
- 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
- 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E

Reset values:
- anode = 4'hF
- cathode = 7'h7F
- dp = 1
- value_ready = 1
- frame_done = 0
- Display register = 0
- pending_full = 0
- digit = 0
- state = IDLE

## Timing
Outputs:
- anode, cathode and dp are registered: one cycle after the state/digit they reflect.
- In BLANK and IDLE: anode = F, cathode = 7F, dp = 1.

Slot timing while enable is high:
- One slot is exactly CLOCK_DIVIDE cycles: BLANK for BLANK_CYCLES, then DRIVE for CLOCK_DIVIDE − BLANK_CYCLES.
- One frame is 4·CLOCK_DIVIDE cycles.

frame_done:
- Asserted on the boundary cycle.
- Never asserted in IDLE or when leaving DRIVE because of enable falling.

Latency:
- A value accepted in frame k is displayed from the first DRIVE of frame k+1.

Reset:
- Assertion forces all outputs to their reset values immediately (asynchronous).
- After release, the first BLANK starts on the first clock edge with enable high.

## Structure
Shared package display_pkg:
- State enum {IDLE, BLANK, DRIVE}.
- SEG_BLANK = 7'h7F.
- ANODE_OFF = 4'hF.
- Cathode constants for 0–F.

Sub-module hex_to_seg7:
- Combinational 4-bit → 7-bit active-low decoder.
- Instantiated once, fed by the digit-index mux.

Slot counter width: $clog2(CLOCK_DIVIDE).

## Test plan
All scenarios use CLOCK_DIVIDE=8, BLANK_CYCLES=2.
- Reset mid-DRIVE → outputs go to F/7F/1 without waiting for a clock edge; value_ready=1; after release with enable high, digit 0 cycles through BLANK then DRIVE.
- Enable high, value 16'h1234 accepted before frame 0 → from frame 1, each slot shows 2 cycles of anode=F followed by 6 cycles of the digit: anode E/cathode 19, D/30, B/24, 7/79; frame_done pulses every 32 cycles.
- Two back-to-back offers (16'hAAAA, then 16'h5555) → the first is accepted and the second is held off (ready=0) until the boundary; the next frame shows AAAA and the following frame shows 5555.
- suppress_zeros=1 with 16'h0007 and point_data=4'b0100 → digits 3 and 1 dark; digit 2 has cathode=7F and dp=0; digit 0 shows 78.
- enable dropped mid-frame → anode=F from the next cycle; re-enabling starts at digit 0 BLANK and the pending value is preserved.
